cla_seq_subtractor: RTL and testbench
=====================================

// Module: cla_seq_subtractor
// PURPOSE
//   Multi-cycle subtractor (a - b - borrow_in) built on the 3-bit carry-lookahead group.
//   Each cycle it processes one GROUP_W-bit slice as a + ~b + carry and registers the inter-group carry.
//   It is the subtract/borrow side of the adder family.
//   Valid/ready on input and output; sits in the datapath where area matters more than latency.
// PARAMETERS
//   WIDTH    12  operand/result width in bits; must be a multiple of GROUP_W
//   GROUP_W   3  bits resolved per cycle by one CLA group; N_GROUPS = WIDTH/GROUP_W >= 1
// PORTS
//   clock      in   1      clock, all state updates on rising edge
//   reset      in   1      reset, synchronous, active-low
//   in_valid   in   1      operands present
//   in_ready   out  1      block can accept operands (high only in IDLE)
//   in_a       in   WIDTH  minuend
//   in_b       in   WIDTH  subtrahend
//   in_borrow  in   1      borrow-in (1 = subtract an extra 1)
//   out_valid  out  1      result registers hold a completed result (high only in DONE)
//   out_ready  in   1      consumer takes the result
//   out_diff   out  WIDTH  a - b - borrow_in, modulo 2^WIDTH
//   out_borrow out  1      unsigned borrow-out = ~final carry (1 when a < b + borrow_in)
//   out_ovf    out  1      signed two's-complement overflow
//   out_zero   out  1      out_diff == 0
// BEHAVIOUR
//   - Reset (reset==0 at a rising edge):
//     - state=IDLE, group counter=0, carry=0.
//     - out_diff/out_borrow/out_ovf/out_zero=0, out_valid=0.
//     - in_ready=1 from the first cycle after the reset edge.
//   - Reset mid-operation aborts. The operation is discarded with no partial result and no out_valid pulse.
//   - FSM IDLE -> BUSY -> DONE -> IDLE:
//     - IDLE: in_ready=1. in_valid&in_ready at an edge:
//       - latch in_a, ~in_b and carry=~in_borrow;
//       - grp=0; clear diff register; go BUSY.
//     - BUSY: in_ready=0, out_valid=0. Each edge:
//       - {c,s} = a[grp slice] + ~b[grp slice] + carry, using CLA propagate/generate (p=a|~b, g=a&~b).
//       - diff[grp slice] <= s; carry <= c; grp <= grp+1.
//       - On the edge where grp==N_GROUPS-1: go DONE and register the flags:
//         - out_borrow = ~c;
//         - out_ovf = (a[W-1] != b[W-1]) & (diff[W-1] != a[W-1]);
//         - out_zero = (full diff == 0).
//     - DONE: out_valid=1. out_* are stable while out_valid & ~out_ready.
//       - out_valid&out_ready at an edge -> IDLE.
//       - in_valid is ignored in DONE (no same-cycle accept).
//   - Latency: out_valid rises exactly N_GROUPS edges after the accepting edge.
//   - Throughput: one op per N_GROUPS+2 cycles when out_ready is held high.
//   - Group counter width = max(1, clog2(N_GROUPS)).
//     - Counter resets to 0 in IDLE; it never wraps inside BUSY.
//   - N_GROUPS==1: BUSY lasts one edge; the result follows the same rules.
//   - out_diff holds its last value after DONE->IDLE until the next accept clears it.
//   - Inputs in_a/in_b/in_borrow need be stable only on the accepting edge.
// TESTING (WIDTH=12, GROUP_W=3)
//   1. a=0x123, b=0x023, bin=0 -> diff=0x100, borrow=0, ovf=0, zero=0; out_valid exactly 4 edges after accept.
//   2. a=0x000, b=0x001, bin=0 -> diff=0xFFF, borrow=1, ovf=0, zero=0 (carry ripples through all 4 groups).
//   3. a=0x800, b=0x001 -> diff=0x7FF, ovf=1, borrow=0. Also a=0x7FF, b=0xFFF -> diff=0x800, ovf=1, borrow=1.
//   4. a=b=0x555: bin=1 -> diff=0xFFF, borrow=1, zero=0; bin=0 -> diff=0x000, borrow=0, zero=1.
//   5. Hold out_ready=0 for 5 cycles in DONE while toggling in_valid/in_a:
//      - out_* stable, in_ready=0, no new op accepted;
//      - after out_ready=1, in_ready=1 on the next cycle.
//   6. Assert reset for one edge while BUSY at grp=2:
//      - next cycle in_ready=1, out_valid=0, outputs 0;
//      - a fresh op a=0x00F, b=0x005 -> diff=0x00A.

Source files
------------

// File: rtl/cla_seq_subtractor.sv
// Multi-cycle subtractor a - b - borrow_in, one GROUP_W-bit carry-lookahead slice per cycle.
// Latency: out_valid rises N_GROUPS edges after the accepting edge; one op per N_GROUPS+2 cycles.
// Backpressure: in_ready only in IDLE; result held stable in DONE until out_ready.
//
// Ports: clock/reset (sync, active-low); in_valid/in_ready/in_a/in_b/in_borrow operand handshake;
//        out_valid/out_ready/out_diff/out_borrow/out_ovf/out_zero result handshake and flags.
module cla_seq_subtractor #(
   parameter int WIDTH   = 12,
   parameter int GROUP_W = 3
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_borrow,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_diff,
   output logic             out_borrow,
   output logic             out_ovf,
   output logic             out_zero
);

   localparam int N_GROUPS = WIDTH / GROUP_W;
   localparam int CNT_W    = (N_GROUPS > 1) ? $clog2(N_GROUPS) : 1;
   localparam int IDX_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] LAST_GRP = CNT_W'(N_GROUPS - 1);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t           state;
   logic [CNT_W-1:0] grp;
   logic             carry;
   logic [WIDTH-1:0] a_reg;
   logic [WIDTH-1:0] nb_reg;    // subtrahend stored already inverted
   logic [WIDTH-1:0] diff_reg;

   // current slice and its lookahead carries
   logic [IDX_W-1:0]   base;
   logic [GROUP_W-1:0] ga, gb, gp, gg, gs;
   logic [GROUP_W:0]   gc;
   logic [WIDTH-1:0]   next_diff;

   always_comb begin
      logic term;
      logic acc;
      base = IDX_W'(int'(grp) * GROUP_W);
      ga   = a_reg[base +: GROUP_W];
      gb   = nb_reg[base +: GROUP_W];
      gp   = ga | gb;
      gg   = ga & gb;
      gc   = '0;
      gc[0] = carry;
      // flattened lookahead: c[i] = G[i-1:0] | P[i-1:0] & carry_in
      for (int i = 1; i <= GROUP_W; i++) begin
         term = carry;
         for (int j = 0; j < i; j++) term = term & gp[j];
         acc = term;
         for (int j = 0; j < i; j++) begin
            term = gg[j];
            for (int k = j + 1; k < i; k++) term = term & gp[k];
            acc = acc | term;
         end
         gc[i] = acc;
      end
      gs = ga ^ gb ^ gc[GROUP_W-1:0];
      next_diff = diff_reg;
      next_diff[base +: GROUP_W] = gs;
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state      <= IDLE;
         grp        <= '0;
         carry      <= 1'b0;
         a_reg      <= '0;
         nb_reg     <= '0;
         diff_reg   <= '0;
         out_borrow <= 1'b0;
         out_ovf    <= 1'b0;
         out_zero   <= 1'b0;
         in_ready   <= 1'b1;
         out_valid  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               grp <= '0;
               if (in_valid) begin
                  a_reg    <= in_a;
                  nb_reg   <= ~in_b;
                  carry    <= ~in_borrow;
                  diff_reg <= '0;
                  state    <= BUSY;
                  in_ready <= 1'b0;
               end
            end
            BUSY: begin
               diff_reg <= next_diff;
               carry    <= gc[GROUP_W];
               if (grp == LAST_GRP) begin
                  // b's sign bit is ~nb_reg, so "signs differ" is a == nb
                  out_borrow <= ~gc[GROUP_W];
                  out_ovf    <= (a_reg[WIDTH-1] == nb_reg[WIDTH-1]) &&
                                (next_diff[WIDTH-1] != a_reg[WIDTH-1]);
                  out_zero   <= (next_diff == '0);
                  state      <= DONE;
                  out_valid  <= 1'b1;
               end else begin
                  grp <= grp + 1'b1;
               end
            end
            DONE: begin
               if (out_ready) begin
                  state     <= IDLE;
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
               end
            end
            default: begin
               state     <= IDLE;
               in_ready  <= 1'b1;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

   assign out_diff = diff_reg;

endmodule

// File: tb/tb_cla_seq_subtractor.sv
module tb_cla_seq_subtractor;

   logic        clock = 1'b0;
   logic        reset;
   logic        in_valid, in_ready, in_borrow;
   logic [11:0] in_a, in_b;
   logic        out_valid, out_ready;
   logic [11:0] out_diff;
   logic        out_borrow, out_ovf, out_zero;

   int checks = 0;
   int errors = 0;

   always #5 clock = ~clock;

   cla_seq_subtractor #(.WIDTH(12), .GROUP_W(3)) dut (
      .clock(clock), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_borrow(in_borrow),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_diff(out_diff), .out_borrow(out_borrow),
      .out_ovf(out_ovf), .out_zero(out_zero)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Present operands for one accepting edge, then scramble them.
   task automatic start_op(input logic [11:0] a, input logic [11:0] b, input logic bin);
      @(negedge clock);
      check("in_ready_idle", 32'(in_ready), 32'd1);
      in_valid  = 1'b1;
      in_a      = a;
      in_b      = b;
      in_borrow = bin;
      @(posedge clock);
      #1;
      in_valid  = 1'b0;
      in_a      = 12'hABC;
      in_b      = 12'h3C5;
      in_borrow = ~bin;
      check("in_ready_busy", 32'(in_ready), 32'd0);
   endtask

   task automatic wait_done(input string tag);
      int edges = 0;
      while (!out_valid && edges < 20) begin
         @(posedge clock);
         #1;
         edges++;
      end
      check({tag, "_latency"}, 32'(edges), 32'd4);
   endtask

   task automatic check_result(input string tag, input logic [11:0] d,
                               input logic bo, input logic ov, input logic z);
      @(negedge clock);
      check({tag, "_valid"},  32'(out_valid),  32'd1);
      check({tag, "_diff"},   32'(out_diff),   32'(d));
      check({tag, "_borrow"}, 32'(out_borrow), 32'(bo));
      check({tag, "_ovf"},    32'(out_ovf),    32'(ov));
      check({tag, "_zero"},   32'(out_zero),   32'(z));
   endtask

   task automatic release_result(input string tag);
      @(negedge clock);
      out_ready = 1'b1;
      @(posedge clock);
      #1;
      out_ready = 1'b0;
      check({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
      check({tag, "_ready_back"}, 32'(in_ready),  32'd1);
   endtask

   task automatic run_op(input string tag, input logic [11:0] a, input logic [11:0] b,
                         input logic bin, input logic [11:0] d,
                         input logic bo, input logic ov, input logic z);
      start_op(a, b, bin);
      wait_done(tag);
      check_result(tag, d, bo, ov, z);
      release_result(tag);
   endtask

   initial begin
      reset     = 1'b0;
      in_valid  = 1'b0;
      in_a      = '0;
      in_b      = '0;
      in_borrow = 1'b0;
      out_ready = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      check("rst_in_ready",  32'(in_ready),  32'd1);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_diff",      32'(out_diff),  32'd0);
      check("rst_flags", 32'({out_borrow, out_ovf, out_zero}), 32'd0);
      reset = 1'b1;

      // directed vectors: tag, a, b, bin, diff, borrow, ovf, zero
      run_op("basic",    12'h123, 12'h023, 1'b0, 12'h100, 1'b0, 1'b0, 1'b0);
      run_op("ripple",   12'h000, 12'h001, 1'b0, 12'hFFF, 1'b1, 1'b0, 1'b0);
      run_op("ovf_neg",  12'h800, 12'h001, 1'b0, 12'h7FF, 1'b0, 1'b1, 1'b0);
      run_op("ovf_pos",  12'h7FF, 12'hFFF, 1'b0, 12'h800, 1'b1, 1'b1, 1'b0);
      run_op("eq_bin1",  12'h555, 12'h555, 1'b1, 12'hFFF, 1'b1, 1'b0, 1'b0);
      run_op("eq_bin0",  12'h555, 12'h555, 1'b0, 12'h000, 1'b0, 1'b0, 1'b1);

      // backpressure: hold result while poking the input side
      start_op(12'h123, 12'h023, 1'b0);
      wait_done("hold");
      for (int i = 0; i < 5; i++) begin
         @(negedge clock);
         in_valid = ~in_valid;
         in_a     = in_a + 12'h111;
         @(negedge clock);
         check("hold_valid",  32'(out_valid),  32'd1);
         check("hold_ready",  32'(in_ready),   32'd0);
         check("hold_diff",   32'(out_diff),   32'h100);
         check("hold_borrow", 32'(out_borrow), 32'd0);
      end
      in_valid = 1'b0;
      release_result("hold");

      // reset in the middle of BUSY (grp==2)
      start_op(12'h0FF, 12'h001, 1'b0);
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b0;
      @(posedge clock);
      #1;
      reset = 1'b1;
      check("abort_in_ready",  32'(in_ready),  32'd1);
      check("abort_out_valid", 32'(out_valid), 32'd0);
      check("abort_diff",      32'(out_diff),  32'd0);
      check("abort_flags", 32'({out_borrow, out_ovf, out_zero}), 32'd0);
      begin
         logic seen = 1'b0;
         for (int i = 0; i < 6; i++) begin
            @(posedge clock);
            #1;
            seen = seen | out_valid;
         end
         check("abort_no_pulse", 32'(seen), 32'd0);
      end
      run_op("fresh", 12'h00F, 12'h005, 1'b0, 12'h00A, 1'b0, 1'b0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
